// File: rtl/conv3x3_pipe.sv
// 3x3 signed-kernel convolution, 3-stage pipeline (multiply, sum, round/shift/saturate) with frame counter.
// Optional: define CONV3X3_ABS_EN to take |sum| before rounding (edge-magnitude mode).
module conv3x3_pipe #(
  parameter int PW    = 8,
  parameter int CW    = 8,
  parameter int SHIFT = 4,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coef_wr,
  input  logic [3:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  input  logic          in_valid,
  input  logic [PW-1:0] pixel1,
  input  logic [PW-1:0] pixel2,
  input  logic [PW-1:0] pixel3,
  input  logic [PW-1:0] pixel4,
  input  logic [PW-1:0] pixel5,
  input  logic [PW-1:0] pixel6,
  input  logic [PW-1:0] pixel7,
  input  logic [PW-1:0] pixel8,
  input  logic [PW-1:0] pixel9,
  output logic          out_valid,
  output logic [PW-1:0] out_pixel,
  output logic          frame_done,
  output logic          busy
);

  localparam int PRW  = PW + CW + 1;
  localparam int SW   = PW + CW + 5;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CNTW = $clog2(NPIX);

  localparam logic signed [CW-1:0] COEF_ONE = CW'(1 << SHIFT);
  localparam logic signed [SW:0]   RND      = (SW+1)'(1 << (SHIFT - 1));
  localparam logic signed [SW:0]   SAT_HI   = (SW+1)'((1 << PW) - 1);
  localparam logic [CNTW-1:0]      CNT_LAST = CNTW'(NPIX - 1);

  logic [PW-1:0]          pix [9];
  logic signed [CW-1:0]   coef_q [9];
  logic signed [CW-1:0]   coef_d [9];
  logic signed [PRW-1:0]  prod_q [9];
  logic signed [PRW-1:0]  prod_d [9];
  logic signed [SW-1:0]   sum_q, sum_d;
  logic signed [SW:0]     mag, rnd, shr;
  logic                   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [PW-1:0]          out_pixel_q, out_pixel_d;
  logic                   frame_done_q, frame_done_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;

  always_comb begin
    pix = '{pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8, pixel9};
  end

  // Bank updates at the edge; S1 reads coef_q, so a write lands on the next sampled window.
  always_comb begin
    coef_d = coef_q;
    if (coef_wr && (coef_addr < 4'd9)) begin
      coef_d[coef_addr] = coef_data;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      prod_d[k] = $signed(PRW'(pix[k])) *
                  $signed({{(PRW-CW){coef_q[k][CW-1]}}, coef_q[k]});
    end
    v1_d = in_valid;
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      sum_d = sum_d + $signed({{(SW-PRW){prod_q[k][PRW-1]}}, prod_q[k]});
    end
    v2_d = v1_q;
  end

  always_comb begin
    mag = {sum_q[SW-1], sum_q};
`ifdef CONV3X3_ABS_EN
    if (mag < 0) begin
      mag = -mag;
    end
`endif
    rnd = mag + RND;
    shr = rnd >>> SHIFT;
    out_pixel_d = '0;
    if (v2_q) begin
      if (shr < 0) begin
        out_pixel_d = '0;
      end else if (shr > SAT_HI) begin
        out_pixel_d = '1;
      end else begin
        out_pixel_d = shr[PW-1:0];
      end
    end
    v3_d = v2_q;
  end

  // Counter advances as S3 loads, so frame_done lines up with the registered output pixel.
  always_comb begin
    frame_done_d = v2_q && (cnt_q == CNT_LAST);
    cnt_d        = cnt_q;
    if (v2_q) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 9; k++) begin
        coef_q[k] <= (k == 4) ? COEF_ONE : '0;
        prod_q[k] <= '0;
      end
      sum_q        <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      out_pixel_q  <= '0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      for (int unsigned k = 0; k < 9; k++) begin
        coef_q[k] <= coef_d[k];
        prod_q[k] <= prod_d[k];
      end
      sum_q        <= sum_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      out_pixel_q  <= out_pixel_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid  = v3_q;
  assign out_pixel  = out_pixel_q;
  assign frame_done = frame_done_q;
  assign busy       = v1_q | v2_q | v3_q;

endmodule
